// File: rtl/traffic_light_monitor_if.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor_if
//   Bundle of the four lane light buses of the four-way intersection.
//   Each bus is one-hot: 3'b100 red, 3'b010 yellow, 3'b001 green.
//
//   Signals:
//     n_lights  [2:0]  north lane lights
//     s_lights  [2:0]  south lane lights
//     e_lights  [2:0]  east lane lights
//     w_lights  [2:0]  west lane lights
//
//   Modports:
//     master  drives the lights (the controller, or a bench driver)
//     slave   observes the lights (the monitor)
// -----------------------------------------------------------------------------
interface traffic_light_monitor_if;
  logic [2:0] n_lights;
  logic [2:0] s_lights;
  logic [2:0] e_lights;
  logic [2:0] w_lights;

  modport master (output n_lights, s_lights, e_lights, w_lights);
  modport slave  (input  n_lights, s_lights, e_lights, w_lights);
endinterface

// File: rtl/traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// traffic_light_monitor
//   Passive checker for the four-way traffic-light controller. Every clock it
//   samples the four lane buses, decodes the active phase, checks each phase's
//   dwell time against its programmed length, flags illegal encodings,
//   conflicting greens and out-of-order transitions, and counts completed
//   N -> S -> E -> W rotations. All outputs are registered (one-cycle latency).
//
//   Parameters:
//     GREEN_CYCLES   required cycles per green phase
//     YELLOW_CYCLES  required cycles per yellow phase
//     CNT_W          dwell counter width, must hold GREEN_CYCLES + 1
//
//   Ports:
//     clk           sole clock, rising edge
//     rst_a         synchronous active-high reset
//     lights        lane light buses (slave modport, observe only)
//     phase         decoded phase 0..7 (N, N_Y, S, S_Y, E, E_Y, W, W_Y)
//     phase_valid   phase reflects a legal sample
//     err_illegal   pulse: bad bus code, or all lanes red
//     err_conflict  pulse: valid codes but two or more lanes non-red
//     err_sequence  pulse: legal phase change that is not to the successor
//     err_dwell     pulse: a phase ran short or over-stayed
//     err_sticky    OR of all error pulses, held until reset
//     rot_done      pulse on a legal west_y -> north transition
//     rotation_cnt  completed rotations, wraps 255 -> 0
//     state_dbg     current FSM state (0 ACQUIRE, 1 TRACK)
//
//   Handshake: none. The lane buses carry no valid/ready; every clock edge is
//   a sample, and the monitor never back-pressures the controller.
// -----------------------------------------------------------------------------
module traffic_light_monitor #(
  parameter int GREEN_CYCLES  = 8,
  parameter int YELLOW_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic                          clk,
  input  logic                          rst_a,
  traffic_light_monitor_if.slave        lights,
  output logic [2:0]                    phase,
  output logic                          phase_valid,
  output logic                          err_illegal,
  output logic                          err_conflict,
  output logic                          err_sequence,
  output logic                          err_dwell,
  output logic                          err_sticky,
  output logic                          rot_done,
  output logic [7:0]                    rotation_cnt,
  output logic                          state_dbg
);

  typedef enum logic {
    ACQUIRE = 1'b0,
    TRACK   = 1'b1
  } state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] DWELL_MAX  = '1;
  localparam logic [CNT_W-1:0] GREEN_LIM  = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] YELLOW_LIM = CNT_W'(YELLOW_CYCLES);

  // ---------------------------------------------------------------------------
  // Sample decode (combinational). Index 0..3 = north, south, east, west, so
  // the lane index times two is the green phase of that lane.
  // ---------------------------------------------------------------------------
  logic [3:0][2:0] codes;
  logic [3:0]      code_ok;
  logic [3:0]      non_red;
  logic [2:0]      non_red_cnt;
  logic            all_ok;
  logic            sample_legal;
  logic            illegal_c;
  logic            conflict_c;
  logic [2:0]      sample_phase;

  assign codes = {lights.w_lights, lights.e_lights, lights.s_lights, lights.n_lights};

  always_comb begin
    code_ok      = '0;
    non_red      = '0;
    non_red_cnt  = '0;
    sample_phase = '0;
    for (int i = 0; i < 4; i++) begin
      code_ok[i]  = (codes[i] == RED) || (codes[i] == YEL) || (codes[i] == GRN);
      non_red[i]  = (codes[i] != RED);
      non_red_cnt = non_red_cnt + {2'b00, non_red[i]};
      // Only meaningful when exactly one lane is non-red; otherwise unused.
      if (non_red[i]) begin
        sample_phase = {i[1:0], (codes[i] == YEL)};
      end
    end
  end

  assign all_ok       = &code_ok;
  assign sample_legal = all_ok && (non_red_cnt == 3'd1);
  // A bad code masks any conflict; all-red with valid codes is also illegal.
  assign illegal_c    = !all_ok || (non_red_cnt == 3'd0);
  assign conflict_c   = all_ok && (non_red_cnt >= 3'd2);

  // ---------------------------------------------------------------------------
  // State and tracking registers
  // ---------------------------------------------------------------------------
  state_t           state_q,     state_d;
  logic [2:0]       phase_q,     phase_d;
  logic             valid_q,     valid_d;
  logic [CNT_W-1:0] dwell_q,     dwell_d;
  logic             checked_q,   checked_d;
  logic [7:0]       rot_cnt_q,   rot_cnt_d;
  logic             illegal_q,   illegal_d;
  logic             conflict_q,  conflict_d;
  logic             seq_q,       seq_d;
  logic             dwell_err_q, dwell_err_d;
  logic             rot_q,       rot_d;
  logic             sticky_q,    sticky_d;

  logic [CNT_W-1:0] limit;
  logic [2:0]       succ_phase;

  // Limit belongs to the phase currently being tracked; odd phases are yellow.
  assign limit      = phase_q[0] ? YELLOW_LIM : GREEN_LIM;
  assign succ_phase = phase_q + 3'd1;

  always_ff @(posedge clk) begin
    if (rst_a) begin
      state_q     <= ACQUIRE;
      phase_q     <= '0;
      valid_q     <= 1'b0;
      dwell_q     <= '0;
      checked_q   <= 1'b0;
      rot_cnt_q   <= '0;
      illegal_q   <= 1'b0;
      conflict_q  <= 1'b0;
      seq_q       <= 1'b0;
      dwell_err_q <= 1'b0;
      rot_q       <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      valid_q     <= valid_d;
      dwell_q     <= dwell_d;
      checked_q   <= checked_d;
      rot_cnt_q   <= rot_cnt_d;
      illegal_q   <= illegal_d;
      conflict_q  <= conflict_d;
      seq_q       <= seq_d;
      dwell_err_q <= dwell_err_d;
      rot_q       <= rot_d;
      sticky_q    <= sticky_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state / next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    valid_d     = valid_q;
    dwell_d     = dwell_q;
    checked_d   = checked_q;
    rot_cnt_d   = rot_cnt_q;
    illegal_d   = illegal_c;
    conflict_d  = conflict_c;
    seq_d       = 1'b0;
    dwell_err_d = 1'b0;
    rot_d       = 1'b0;

    case (state_q)
      ACQUIRE: begin
        if (sample_legal) begin
          // Phase start was not observed, so its length cannot be judged short.
          state_d   = TRACK;
          phase_d   = sample_phase;
          valid_d   = 1'b1;
          dwell_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          checked_d = 1'b0;
        end else begin
          valid_d = 1'b0;
        end
      end

      TRACK: begin
        if (!sample_legal) begin
          // phase keeps its last value; only validity drops.
          state_d = ACQUIRE;
          valid_d = 1'b0;
        end else if (sample_phase == phase_q) begin
          // Over-stay fires once, on the step that would take dwell past the
          // limit; later cycles see dwell > limit and stay quiet.
          if (dwell_q == limit) begin
            dwell_err_d = 1'b1;
          end
          if (dwell_q != DWELL_MAX) begin
            dwell_d = dwell_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end else if (sample_phase == succ_phase) begin
          if (checked_q && (dwell_q < limit)) begin
            dwell_err_d = 1'b1;
          end
          phase_d   = sample_phase;
          dwell_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          checked_d = 1'b1;
          if (phase_q == 3'd7) begin
            rot_d     = 1'b1;
            rot_cnt_d = rot_cnt_q + 8'd1;
          end
        end else begin
          // Skipped or reversed phase: the old phase's length is meaningless.
          seq_d     = 1'b1;
          phase_d   = sample_phase;
          dwell_d   = {{(CNT_W-1){1'b0}}, 1'b1};
          checked_d = 1'b0;
        end
      end

      default: begin
        state_d = ACQUIRE;
        valid_d = 1'b0;
      end
    endcase

    sticky_d = sticky_q | illegal_d | conflict_d | seq_d | dwell_err_d;
  end

  // ---------------------------------------------------------------------------
  // Outputs (all registered)
  // ---------------------------------------------------------------------------
  assign phase        = phase_q;
  assign phase_valid  = valid_q;
  assign err_illegal  = illegal_q;
  assign err_conflict = conflict_q;
  assign err_sequence = seq_q;
  assign err_dwell    = dwell_err_q;
  assign err_sticky   = sticky_q;
  assign rot_done     = rot_q;
  assign rotation_cnt = rot_cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// -----------------------------------------------------------------------------
// tb_traffic_light_monitor
//   Self-checking bench for traffic_light_monitor with default parameters.
//   A table of single-sample vectors exercises decode, error priority and
//   phase transitions; hand-written sequences cover dwell, rotation, conflict
//   recovery, skip and reset corner cases.
// -----------------------------------------------------------------------------
module tb_traffic_light_monitor;

  logic       clk;
  logic       rst_a;
  logic [2:0] phase;
  logic       phase_valid;
  logic       err_illegal;
  logic       err_conflict;
  logic       err_sequence;
  logic       err_dwell;
  logic       err_sticky;
  logic       rot_done;
  logic [7:0] rotation_cnt;
  logic       state_dbg;

  int tests_run;
  int tests_failed;

  traffic_light_monitor_if bus ();

  traffic_light_monitor #(
    .GREEN_CYCLES  (8),
    .YELLOW_CYCLES (4),
    .CNT_W         (4)
  ) dut (
    .clk          (clk),
    .rst_a        (rst_a),
    .lights       (bus.slave),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .err_illegal  (err_illegal),
    .err_conflict (err_conflict),
    .err_sequence (err_sequence),
    .err_dwell    (err_dwell),
    .err_sticky   (err_sticky),
    .rot_done     (rot_done),
    .rotation_cnt (rotation_cnt),
    .state_dbg    (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  // Drive one sample, let it be captured, then settle before checking.
  task automatic step(input logic [2:0] n, input logic [2:0] s,
                      input logic [2:0] e, input logic [2:0] w);
    bus.n_lights = n;
    bus.s_lights = s;
    bus.e_lights = e;
    bus.w_lights = w;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [11:0] lights_of(input logic [2:0] p);
    logic [11:0] r;
    logic [2:0]  c;
    r = {R, R, R, R};
    c = p[0] ? Y : G;
    case (p[2:1])
      2'd0: r[11:9] = c;
      2'd1: r[8:6]  = c;
      2'd2: r[5:3]  = c;
      default: r[2:0] = c;
    endcase
    return r;
  endfunction

  task automatic step_ph(input logic [2:0] p);
    logic [11:0] l;
    l = lights_of(p);
    step(l[11:9], l[8:6], l[5:3], l[2:0]);
  endtask

  task automatic drive_phase(input logic [2:0] p, input int len);
    for (int k = 0; k < len; k++) step_ph(p);
  endtask

  task automatic drive_rotations(input int nrot);
    for (int r = 0; r < nrot; r++)
      for (int p = 0; p < 8; p++)
        drive_phase(3'(p), (p % 2 == 1) ? 4 : 8);
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ph, input logic vld,
                           input logic ill, input logic con, input logic seq,
                           input logic dw, input logic rot, input logic sticky,
                           input logic [7:0] cnt);
    chk($sformatf("%s.phase", tag),        32'(phase),        32'(ph));
    chk($sformatf("%s.phase_valid", tag),  32'(phase_valid),  32'(vld));
    chk($sformatf("%s.err_illegal", tag),  32'(err_illegal),  32'(ill));
    chk($sformatf("%s.err_conflict", tag), 32'(err_conflict), 32'(con));
    chk($sformatf("%s.err_sequence", tag), 32'(err_sequence), 32'(seq));
    chk($sformatf("%s.err_dwell", tag),    32'(err_dwell),    32'(dw));
    chk($sformatf("%s.rot_done", tag),     32'(rot_done),     32'(rot));
    chk($sformatf("%s.err_sticky", tag),   32'(err_sticky),   32'(sticky));
    chk($sformatf("%s.rotation_cnt", tag), 32'(rotation_cnt), 32'(cnt));
  endtask

  // Reset with a conflicting sample on the same edge: the error must be dropped.
  task automatic do_reset(input string tag);
    rst_a = 1'b1;
    step(G, G, R, R);
    check_all(tag, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    chk($sformatf("%s.state", tag), 32'(state_dbg), 32'd0);
    rst_a = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [2:0] n, s, e, w;
    logic [2:0] ph;
    logic       vld, ill, con, seq, dw, rot, sticky;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int exp_cnt;
    logic exp_rot;

    tests_run    = 0;
    tests_failed = 0;
    rst_a        = 1'b1;
    bus.n_lights = R;
    bus.s_lights = R;
    bus.e_lights = R;
    bus.w_lights = R;

    //            n  s  e  w      ph  v  il cn sq dw rt st cnt
    tbl[0]  = '{G, R, R, R,      0, 1, 0, 0, 0, 0, 0, 0, 0};  // acquire north
    tbl[1]  = '{G, G, R, R,      0, 0, 0, 1, 0, 0, 0, 1, 0};  // conflict
    tbl[2]  = '{3'b011, G, R, R, 0, 0, 1, 0, 0, 0, 0, 1, 0};  // bad code masks conflict
    tbl[3]  = '{R, R, R, R,      0, 0, 1, 0, 0, 0, 0, 1, 0};  // all red
    tbl[4]  = '{R, R, Y, R,      5, 1, 0, 0, 0, 0, 0, 1, 0};  // acquire east_y
    tbl[5]  = '{R, R, R, G,      6, 1, 0, 0, 0, 0, 0, 1, 0};  // successor, unchecked
    tbl[6]  = '{R, G, R, R,      2, 1, 0, 0, 1, 0, 0, 1, 0};  // skip: no short check
    tbl[7]  = '{R, Y, R, R,      3, 1, 0, 0, 0, 0, 0, 1, 0};  // successor, unchecked
    tbl[8]  = '{R, R, R, 3'b111, 3, 0, 1, 0, 0, 0, 0, 1, 0};  // bad code, phase holds
    tbl[9]  = '{R, R, R, 3'b000, 3, 0, 1, 0, 0, 0, 0, 1, 0};  // bad code
    tbl[10] = '{R, Y, G, R,      3, 0, 0, 1, 0, 0, 0, 1, 0};  // yellow+green conflict
    tbl[11] = '{R, R, R, Y,      7, 1, 0, 0, 0, 0, 0, 1, 0};  // acquire west_y
    tbl[12] = '{G, R, R, R,      0, 1, 0, 0, 0, 0, 1, 1, 1};  // 7 -> 0 rotation

    repeat (2) @(posedge clk);
    #1;

    // ---- Table-driven decode / transition vectors --------------------------
    do_reset("tbl_reset");
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].n, tbl[i].s, tbl[i].e, tbl[i].w);
      check_all($sformatf("tbl%0d", i), tbl[i].ph, tbl[i].vld, tbl[i].ill, tbl[i].con,
                tbl[i].seq, tbl[i].dw, tbl[i].rot, tbl[i].sticky, tbl[i].cnt);
    end

    // ---- Three legal rotations from reset ----------------------------------
    do_reset("rot_reset");
    exp_cnt = 0;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 8; p++) begin
        for (int k = 0; k < ((p % 2 == 1) ? 4 : 8); k++) begin
          step_ph(3'(p));
          exp_rot = (r > 0) && (p == 0) && (k == 0);
          if (exp_rot) exp_cnt++;
          check_all($sformatf("rot%0d.p%0d.k%0d", r, p, k), 3'(p), 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b0, exp_rot, 1'b0, 8'(exp_cnt));
        end
      end
    end
    step_ph(3'd0);
    check_all("rot_final", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);

    // ---- Short green --------------------------------------------------------
    do_reset("short_reset");
    step_ph(3'd7);
    check_all("short_wy", 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    step_ph(3'd0);
    check_all("short_n0", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
    for (int k = 1; k < 5; k++) begin
      step_ph(3'd0);
      check_all($sformatf("short_n%0d", k), 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b0, 8'd1);
    end
    step_ph(3'd1);
    check_all("short_ny", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'd1);
    step_ph(3'd1);
    check_all("short_ny2", 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

    // ---- Yellow over-stay ---------------------------------------------------
    do_reset("ovr_reset");
    step_ph(3'd7);
    drive_phase(3'd0, 8);
    chk("ovr_green_ok.err_sticky", 32'(err_sticky), 32'd0);
    for (int k = 0; k < 6; k++) begin
      step_ph(3'd1);
      check_all($sformatf("ovr_ny%0d", k), 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'(k == 4),
                1'b0, 1'(k >= 4), 8'd1);
    end
    step_ph(3'd2);
    check_all("ovr_south", 3'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

    // ---- Long green: single pulse, dwell saturates without wrap -------------
    do_reset("sat_reset");
    for (int k = 0; k < 30; k++) begin
      step_ph(3'd0);
      chk($sformatf("sat_n%0d.err_dwell", k), 32'(err_dwell), 32'(k == 8));
    end
    step_ph(3'd1);
    chk("sat_ny.err_dwell", 32'(err_dwell), 32'd0);
    chk("sat_ny.phase", 32'(phase), 32'd1);

    // ---- Conflict during east green, then unchecked resume ------------------
    do_reset("cfl_reset");
    step_ph(3'd3);
    drive_phase(3'd4, 2);
    step(G, R, G, R);
    check_all("cfl_hit", 3'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    for (int k = 0; k < 3; k++) begin
      step_ph(3'd4);
      check_all($sformatf("cfl_e%0d", k), 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                1'b0, 1'b1, 8'd0);
    end
    step_ph(3'd5);
    check_all("cfl_ey", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);

    // ---- Skip north_y -> east ----------------------------------------------
    do_reset("skip_reset");
    step_ph(3'd7);
    drive_phase(3'd0, 8);
    drive_phase(3'd1, 4);
    step_ph(3'd4);
    check_all("skip_e", 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'd1);
    drive_phase(3'd4, 7);
    chk("skip_e8.err_dwell", 32'(err_dwell), 32'd0);
    step_ph(3'd5);
    check_all("skip_ey", 3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);

    // ---- Illegal code, then reset mid-operation -----------------------------
    do_reset("rst_reset");
    drive_rotations(2);
    step_ph(3'd0);
    check_all("rst_two_rot", 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd2);
    step(G, R, R, 3'b011);
    check_all("rst_bad_w", 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2);
    drive_phase(3'd0, 2);
    chk("rst_track.state", 32'(state_dbg), 32'd1);
    chk("rst_track.phase_valid", 32'(phase_valid), 32'd1);
    do_reset("rst_mid");
    step_ph(3'd4);
    check_all("rst_after", 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // ---- Final report -------------------------------------------------------
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Passive checker for the four-way traffic-light controller's output buses. It samples `n_lights`, `s_lights`, `e_lights` and `w_lights` every clock, decodes the active phase, and checks each phase's dwell time against its programmed length. It also flags illegal encodings, conflicting greens and out-of-order transitions, and counts completed N→S→E→W rotations. It sits beside the controller in the intersection top level and in the bench as the protocol checker.

## Interface
- `GREEN_CYCLES`, default 8: required cycles per green phase.
- `YELLOW_CYCLES`, default 4: required cycles per yellow phase.
- `CNT_W`, default 4: dwell counter width. Must hold `GREEN_CYCLES + 1`.
- `clk` input 1: sole clock, rising edge.
- `rst_a` input 1: synchronous, active-high reset.
- `n_lights`, `s_lights`, `e_lights`, `w_lights` input 3 each: lane lights; 3'b100 red, 3'b010 yellow, 3'b001 green.
- `phase` output 3: decoded phase; 0 north, 1 north_y, 2 south, 3 south_y, 4 east, 5 east_y, 6 west, 7 west_y.
- `phase_valid` output 1: `phase` reflects a legal sample.
- `err_illegal` output 1: pulse; a lane bus is not in {100, 010, 001}, or all lanes are red.
- `err_conflict` output 1: pulse; two or more lanes are non-red.
- `err_sequence` output 1: pulse; a legal phase change is not to the successor phase.
- `err_dwell` output 1: pulse; a phase ran short or over-stayed.
- `err_sticky` output 1: OR of all error pulses, held until reset.
- `rot_done` output 1: pulse on a legal west_y→north transition.
- `rotation_cnt` output 8: completed rotations, wraps 255→0.

## Operation
- **Decode (combinational per sample).** A sample is legal when every bus is a valid code and exactly one lane is non-red. The phase is that lane plus green or yellow.
- **Error priority.** If any bus code is invalid, `err_illegal` fires and `err_conflict` is suppressed. If all codes are valid but two or more lanes are non-red, `err_conflict` fires. If all codes are valid and all lanes are red, `err_illegal` fires.
- **FSM states.** `ACQUIRE` and `TRACK`. Reset enters `ACQUIRE`.
- **ACQUIRE, legal sample.** Latch the phase. Go to `TRACK` with `dwell`=1 and `checked`=0, because the phase start was not seen.
- **ACQUIRE, illegal sample.** Stay in `ACQUIRE`. `phase_valid`=0.
- **TRACK, same phase.** `dwell` increments, saturating at 2^CNT_W−1.
- **Over-stay.** The limit is `GREEN_CYCLES` for green phases and `YELLOW_CYCLES` for yellow. `err_dwell` pulses once, on the cycle `dwell` would become limit+1. This check applies whether or not `checked` is set.
- **TRACK, successor phase** (`(phase+1) mod 8`):
  - If `checked`=1 and `dwell` < limit of the old phase: pulse `err_dwell`.
  - Adopt the new phase with `dwell`=1 and `checked`=1.
  - If the transition is 7→0: pulse `rot_done` and increment `rotation_cnt`.
- **TRACK, non-successor legal phase.**
  - Pulse `err_sequence`.
  - Adopt the new phase with `dwell`=1 and `checked`=0.
  - No short-dwell check on the old phase. No rotation count.
- **TRACK, illegal sample.** Pulse the relevant error. Go to `ACQUIRE` with `phase_valid`=0; `phase` holds its last value.
- **Independence.** Error pulses are independent and may coincide (e.g. `err_sequence` is not suppressed by `err_dwell`). `err_sticky` sets on any pulse.

## Timing
- **Latency.** All outputs are registered. Inputs present before rising edge k are reflected in outputs after edge k (one-register latency). No combinational input→output path.
- **Reset values.** `phase`=0, `phase_valid`=0, all `err_*`=0, `err_sticky`=0, `rot_done`=0, `rotation_cnt`=0. Internally `dwell`=0, `checked`=0, state `ACQUIRE`.
- **Reset mid-operation.** `rst_a` dominates any same-edge event: an error or rotation on that edge is discarded. The sample on the first edge after `rst_a` deasserts is handled as `ACQUIRE`.
- **Pulse width.** Pulses are exactly one cycle wide. Over-stay does not re-pulse while the phase is held, and `dwell` saturates without wrap.
- **Matching the controller.** The controller comes out of reset in north with count 0. With defaults it gives 8 green and 4 yellow cycles per phase. The first phase after reset is acquired unchecked, and the monitor reports no errors for that stream.

## Test plan
1. **Legal rotations.** Drive the legal 48-cycle rotation three times from reset with defaults. Expect no `err_*` pulses and `err_sticky`=0. Expect `rot_done` pulses one cycle after each west_y→north sample and `rotation_cnt`=3. `phase` tracks the input with one-cycle lag.
2. **Short green.** Hold north green 5 cycles, then north_y. Expect one `err_dwell` pulse on the north_y output cycle and `phase`=1. Expect `err_sticky`=1 thereafter.
3. **Yellow over-stay.** Hold north_y for 6 cycles. Expect a single `err_dwell` pulse at the 5th sample's output cycle and none at the 6th. Then south follows with no further error.
4. **Conflict and resume.** During east green, drive `n_lights`=001. Expect `err_conflict`=1, `err_illegal`=0, `phase_valid`=0. Then resume east green for 3 cycles followed by east_y. Expect no short `err_dwell`, because the resumed phase is unchecked.
5. **Skip.** Go north_y → east directly. Expect `err_sequence` pulse with `phase`=4. The following east→east_y at correct dwell is accepted without a short check.
6. **Illegal code, then reset.** Drive `w_lights`=011. Expect `err_illegal`. Then assert `rst_a` for one cycle during TRACK after 2 rotations. Expect all outputs cleared on that edge, including `rotation_cnt`=0 and `err_sticky`=0.
